uart_hello_loopback: RTL and testbench

//  Self-test UART block. A message ROM source streams the fixed 13-byte string "Hello World!\n" into a UART transmitter.
//  The serial line loops back internally into a UART receiver, which reports each byte and keeps a running checksum.

---
 rtl/uart_hello_loopback.sv | 150 +++++++++++++++
 tb/tb_uart_hello_loopback.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/uart_hello_loopback.sv
// Self-test UART: a ROM source streams "Hello World!\n" through a UART TX whose
// line loops back into a UART RX that reports each byte and keeps a running sum.
module uart_hello_loopback #(
   parameter int cycles_per_bit = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        o_serial,
   output logic [7:0]  o_data,
   output logic        o_valid,
   output logic        o_done,
   output logic [31:0] o_sum
);
   localparam int CW = $clog2(2 * cycles_per_bit) + 1;
   localparam logic [CW-1:0] BIT_LAST  = CW'(cycles_per_bit - 1);
   // First RX sample lands mid-way into data bit 0, counted from start detection.
   localparam logic [CW-1:0] FIRST_SMP = CW'(cycles_per_bit + cycles_per_bit / 2 - 1);

   function automatic logic [7:0] msg_rom(input logic [3:0] idx);
      case (idx)
         4'd0:    msg_rom = 8'h48;
         4'd1:    msg_rom = 8'h65;
         4'd2:    msg_rom = 8'h6C;
         4'd3:    msg_rom = 8'h6C;
         4'd4:    msg_rom = 8'h6F;
         4'd5:    msg_rom = 8'h20;
         4'd6:    msg_rom = 8'h57;
         4'd7:    msg_rom = 8'h6F;
         4'd8:    msg_rom = 8'h72;
         4'd9:    msg_rom = 8'h6C;
         4'd10:   msg_rom = 8'h64;
         4'd11:   msg_rom = 8'h21;
         4'd12:   msg_rom = 8'h0A;
         default: msg_rom = 8'h00;
      endcase
   endfunction

   typedef enum logic [1:0] {SRC_WAIT, SRC_SEND, SRC_DONE} src_state_t;
   typedef enum logic {RX_IDLE, RX_BITS} rx_state_t;

   src_state_t    src_state;
   logic [3:0]    cursor;

   logic          tx_busy;
   logic          tx_line;
   logic [8:0]    tx_shift;
   logic [3:0]    tx_bit;
   logic [CW-1:0] tx_cnt;

   rx_state_t     rx_state;
   logic [3:0]    rx_bit;
   logic [CW-1:0] rx_cnt;
   logic [7:0]    rx_shift;

   logic tx_idle, src_req, accept;

   assign tx_idle  = !tx_busy;
   assign src_req  = (src_state == SRC_SEND);
   assign accept   = src_req && tx_idle;
   assign o_serial = tx_line;
   assign o_done   = (src_state == SRC_DONE) && tx_idle;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src_state <= SRC_WAIT;
         cursor    <= 4'd0;
      end else begin
         case (src_state)
            SRC_WAIT: if (tx_idle) src_state <= SRC_SEND;
            SRC_SEND: if (accept) begin
               cursor <= cursor + 4'd1;
               if (cursor == 4'd12) src_state <= SRC_DONE;
            end
            SRC_DONE: src_state <= SRC_DONE;
            default:  src_state <= SRC_WAIT;
         endcase
      end
   end

   // tx_shift holds the bits still to go out (data then stop); the start bit
   // is driven directly at the accept edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_busy  <= 1'b0;
         tx_line  <= 1'b1;
         tx_shift <= '0;
         tx_bit   <= 4'd0;
         tx_cnt   <= '0;
      end else if (accept) begin
         tx_busy  <= 1'b1;
         tx_line  <= 1'b0;
         tx_shift <= {1'b1, msg_rom(cursor)};
         tx_bit   <= 4'd0;
         tx_cnt   <= '0;
      end else if (tx_busy) begin
         if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 4'd9) begin
               tx_busy <= 1'b0;
               tx_line <= 1'b1;
            end else begin
               tx_line  <= tx_shift[0];
               tx_shift <= {1'b1, tx_shift[8:1]};
               tx_bit   <= tx_bit + 4'd1;
            end
         end else begin
            tx_cnt <= tx_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state <= RX_IDLE;
         rx_bit   <= 4'd0;
         rx_cnt   <= '0;
         rx_shift <= 8'd0;
         o_data   <= 8'd0;
         o_valid  <= 1'b0;
         o_sum    <= 32'd0;
      end else begin
         o_valid <= 1'b0;
         case (rx_state)
            RX_IDLE: if (!tx_line) begin
               rx_state <= RX_BITS;
               rx_cnt   <= FIRST_SMP;
               rx_bit   <= 4'd0;
            end
            RX_BITS: if (rx_cnt == '0) begin
               rx_cnt <= BIT_LAST;
               if (rx_bit == 4'd8) begin
                  // Stop-bit sample: a low stop bit is a framing error and drops the byte.
                  rx_state <= RX_IDLE;
                  if (tx_line) begin
                     o_data  <= rx_shift;
                     o_sum   <= o_sum + {24'd0, rx_shift};
                     o_valid <= 1'b1;
                  end
               end else begin
                  rx_shift <= {tx_line, rx_shift[7:1]};
                  rx_bit   <= rx_bit + 4'd1;
               end
            end else begin
               rx_cnt <= rx_cnt - 1'b1;
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_hello_loopback.sv
// Scoreboard bench: three instances (cpb 3/4/8) checked against a timeline model of the line.
module tb_uart_hello_loopback;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic        ser [3];
   logic [7:0]  dat [3];
   logic        vld [3];
   logic        dn  [3];
   logic [31:0] sm  [3];

   uart_hello_loopback #(.cycles_per_bit(3)) u0 (.clk(clk), .rst_n(rst_n), .o_serial(ser[0]),
      .o_data(dat[0]), .o_valid(vld[0]), .o_done(dn[0]), .o_sum(sm[0]));
   uart_hello_loopback #(.cycles_per_bit(4)) u1 (.clk(clk), .rst_n(rst_n), .o_serial(ser[1]),
      .o_data(dat[1]), .o_valid(vld[1]), .o_done(dn[1]), .o_sum(sm[1]));
   uart_hello_loopback #(.cycles_per_bit(8)) u2 (.clk(clk), .rst_n(rst_n), .o_serial(ser[2]),
      .o_data(dat[2]), .o_valid(vld[2]), .o_done(dn[2]), .o_sum(sm[2]));

   string       hello = "Hello World!\n";
   int          total, pass;
   int          t;
   bit          run;
   int          q0[$], q1[$], q2[$];
   logic [31:0] exp_sum [3];
   logic [7:0]  last_b  [3];

   function automatic int cpb_of(int i);
      return (i == 0) ? 3 : ((i == 1) ? 4 : 8);
   endfunction

   // Frame f starts 2 cycles after release plus f periods of 10*cpb+1.
   function automatic logic exp_line(int c, int tt);
      int p, f, o, b;
      logic [7:0] ch;
      p = 10 * c + 1;
      if (tt < 2) return 1'b1;
      f = (tt - 2) / p;
      o = (tt - 2) % p;
      if (f > 12 || o >= 10 * c) return 1'b1;
      b = o / c;
      if (b == 0) return 1'b0;
      if (b == 9) return 1'b1;
      ch = hello[f];
      return ch[b-1];
   endfunction

   function automatic logic exp_done(int c, int tt);
      return tt >= 2 + 12 * (10 * c + 1) + 10 * c;
   endfunction

   function automatic int pop_q(int i);
      int f = -1;
      case (i)
         0: if (q0.size() > 0) f = q0.pop_front();
         1: if (q1.size() > 0) f = q1.pop_front();
         default: if (q2.size() > 0) f = q2.pop_front();
      endcase
      return f;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act === exp) pass++;
      else $display("FAIL %s t=%0d got=%0h want=%0h", nm, t, act, exp);
   endtask

   always @(posedge clk) if (run) t++;

   always @(negedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_serial%0d", i), {31'd0, ser[i]}, 32'd1);
            chk($sformatf("rst_valid%0d", i),  {31'd0, vld[i]}, 32'd0);
            chk($sformatf("rst_done%0d", i),   {31'd0, dn[i]},  32'd0);
            chk($sformatf("rst_sum%0d", i),    sm[i],           32'd0);
            chk($sformatf("rst_data%0d", i),   {24'd0, dat[i]}, 32'd0);
         end
      end else if (run) begin
         for (int i = 0; i < 3; i++) begin
            int c, f, lo, hi;
            logic [7:0] b;
            c = cpb_of(i);
            chk($sformatf("line%0d", i), {31'd0, ser[i]}, {31'd0, exp_line(c, t)});
            chk($sformatf("done%0d", i), {31'd0, dn[i]},  {31'd0, exp_done(c, t)});
            if (vld[i]) begin
               f = pop_q(i);
               if (f < 0) begin
                  chk($sformatf("extra_valid%0d", i), {31'd0, vld[i]}, 32'd0);
               end else begin
                  b = hello[f];
                  exp_sum[i] = exp_sum[i] + {24'd0, b};
                  last_b[i]  = b;
                  lo = 2 + f * (10 * c + 1) + 9 * c;
                  hi = lo + c + 1;
                  chk($sformatf("data%0d_b%0d", i, f), {24'd0, dat[i]}, {24'd0, b});
                  chk($sformatf("sum%0d_b%0d", i, f), sm[i], exp_sum[i]);
                  chk($sformatf("vld_time%0d_b%0d", i, f), {31'd0, (t >= lo && t <= hi)}, 32'd1);
               end
            end else begin
               chk($sformatf("data_hold%0d", i), {24'd0, dat[i]}, {24'd0, last_b[i]});
            end
         end
      end
   end

   task automatic rel();
      rst_n = 1'b1;
      t = 0;
      run = 1'b1;
      for (int i = 0; i < 3; i++) begin
         exp_sum[i] = 32'd0;
         last_b[i]  = 8'd0;
      end
      for (int f = 0; f < 13; f++) begin
         q0.push_back(f);
         q1.push_back(f);
         q2.push_back(f);
      end
   endtask

   task automatic hit_rst();
      rst_n = 1'b0;
      run = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("midrst_serial%0d", i), {31'd0, ser[i]}, 32'd1);
         chk($sformatf("midrst_valid%0d", i),  {31'd0, vld[i]}, 32'd0);
         chk($sformatf("midrst_sum%0d", i),    sm[i],           32'd0);
         chk($sformatf("midrst_done%0d", i),   {31'd0, dn[i]},  32'd0);
      end
      q0.delete();
      q1.delete();
      q2.delete();
   endtask

   task automatic wait_t(int x);
      while (t < x) @(negedge clk);
      @(posedge clk);
      #2;
   endtask

   initial begin
      total = 0;
      pass = 0;
      run = 1'b0;
      t = 0;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2 rel();
      // Reset in the middle of byte 5 of the cpb=3 instance.
      wait_t(2 + 5 * 31 + $urandom_range(1, 29));
      hit_rst();
      repeat ($urandom_range(1, 6)) @(posedge clk);
      #2 rel();
      wait_t($urandom_range(3, 1000));
      hit_rst();
      repeat ($urandom_range(1, 6)) @(posedge clk);
      #2 rel();
      // Full message on every instance, then 200 quiet cycles past the slowest.
      wait_t(2 + 12 * 81 + 80 + 200);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("final_sum%0d", i),  sm[i], 32'd1095);
         chk($sformatf("final_done%0d", i), {31'd0, dn[i]}, 32'd1);
         chk($sformatf("final_line%0d", i), {31'd0, ser[i]}, 32'd1);
      end
      chk("leftover_q0", q0.size(), 32'd0);
      chk("leftover_q1", q1.size(), 32'd0);
      chk("leftover_q2", q2.size(), 32'd0);
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
